multi_cycle_control_unit: RTL and testbench

//  Moore FSM sequencing the shared multi-cycle RV32I datapath (one ALU, one unified memory port,
//  one register file) over IF/ID/EX/MEM/WB. Decodes the latched IR opcode, issues per-state

---
 rtl/multi_cycle_control_unit_pkg.sv | 54 +++++
 rtl/multi_cycle_control_unit_if.sv | 15 +
 rtl/multi_cycle_control_unit_next_state.sv | 49 ++++
 rtl/multi_cycle_control_unit.sv | 164 ++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM state
// encodings, RV32I major opcodes and the datapath select constants that
// the control unit drives.
package multi_cycle_control_unit_pkg;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_IF   = 4'd1,
    ST_ID   = 4'd2,
    ST_EX   = 4'd3,
    ST_MEM  = 4'd4,
    ST_WB   = 4'd5,
    ST_HALT = 4'd6
  } state_t;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  // alu_class
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  // mem_to_reg
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  // pc_source
  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_ALU    = 2'd1;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd2;

  function automatic logic opcode_known(input logic [6:0] op);
    case (op)
      OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Unified memory port handshake between the control unit (master) and the
// memory (slave).
//   mem_read   request a read, held until mem_ready
//   mem_write  request a write, held until mem_ready
//   i_or_d     address select: 0 = PC (fetch), 1 = ALUOut (data)
//   mem_ready  memory completes the current request this cycle
interface multi_cycle_control_unit_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/multi_cycle_control_unit_next_state.sv
// Next-state logic for the multi-cycle control FSM.
//   state      current state
//   opcode     IR[6:0], meaningful from ID onward
//   mem_ready  memory completes the current request
//   is_halt    ECALL halts (x17 == 10)
//   next       state for the next cycle
module control_next_state
  import multi_cycle_control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       is_halt,
  output state_t     next
);

  always_comb begin
    next = ST_RST;
    case (state)
      ST_RST:  next = ST_IF;
      ST_IF:   next = mem_ready ? ST_ID : ST_IF;
      ST_ID: begin
        case (opcode)
          OP_ARITH, OP_ARITH_IMM, OP_LOAD,
          OP_STORE, OP_BRANCH, OP_JALR: next = ST_EX;
          OP_JAL:                       next = ST_WB;
          OP_ECALL:                     next = is_halt ? ST_HALT : ST_IF;
          default:                      next = ST_IF;
        endcase
      end
      ST_EX: begin
        case (opcode)
          OP_LOAD, OP_STORE: next = ST_MEM;
          OP_BRANCH:         next = ST_IF;
          default:           next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready)             next = ST_MEM;
        else if (opcode == OP_LOAD) next = ST_WB;
        else                        next = ST_IF;
      end
      ST_WB:   next = ST_IF;
      ST_HALT: next = ST_HALT;
      default: next = ST_RST;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Moore control FSM for the shared multi-cycle RV32I datapath
// (IF/ID/EX/MEM/WB). Outputs decode the state register, plus mem_ready
// for ir_write / store completion, bcond for branch pc_source and is_halt
// for ECALL retirement in ID.
//   clk, reset_n   clock, asynchronous active-low reset
//   opcode         IR[6:0]
//   bcond          branch condition from the ALU (EX of branches)
//   is_halt        x17 == 10 (ID of ECALL)
//   mem            memory handshake (master side)
//   ir_write .. pc_source   datapath enables and mux selects
//   halted         sticky, ECALL with is_halt retired
//   illegal_inst   one-cycle pulse in ID on an unknown opcode
//   mem_timeout    sticky, one request waited MEM_TIMEOUT cycles
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 16
)
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [6:0]                  opcode,
  input  logic                        bcond,
  input  logic                        is_halt,
  multi_cycle_control_unit_if.master  mem,
  output logic                        ir_write,
  output logic                        reg_write,
  output logic [1:0]                  mem_to_reg,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [1:0]                  alu_class,
  output logic                        pc_write,
  output logic [1:0]                  pc_source,
  output logic                        halted,
  output logic                        illegal_inst,
  output logic                        mem_timeout
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  logic [STATE_W-1:0] state_q;
  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               waiting;
  logic               mem_read_c;
  logic               mem_write_c;
  logic               i_or_d_c;

  // The register may be wider than the enum; only the low bits encode state.
  assign state   = state_t'(state_q[$bits(state_t)-1:0]);
  assign waiting = ((state == ST_IF) || (state == ST_MEM)) && !mem.mem_ready;
  assign cnt_inc = cnt_q + 1'b1;

  control_next_state u_next (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem.mem_ready),
    .is_halt   (is_halt),
    .next      (state_d)
  );

  // Counter is zero whenever no request is stalled, so it is already clear
  // on every entry into IF or MEM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_W'(ST_RST);
      cnt_q       <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= STATE_W'(state_d);
      if (waiting) begin
        if (cnt_q != TMO) cnt_q <= cnt_inc;
        if ((MEM_TIMEOUT != 0) && (cnt_inc == TMO)) mem_timeout <= 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  always_comb begin
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    i_or_d_c     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = WB_ALUOUT;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RS2;
    alu_class    = ALU_ADD;
    pc_write     = 1'b0;
    pc_source    = PCSRC_PC4;
    halted       = 1'b0;
    illegal_inst = 1'b0;
    case (state)
      ST_IF: begin
        mem_read_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write   = mem.mem_ready;
      end
      ST_ID: begin
        alu_src_b = SRCB_IMM;
        if (opcode == OP_ECALL) begin
          pc_write = !is_halt;
        end else if (!opcode_known(opcode)) begin
          illegal_inst = 1'b1;
          pc_write     = 1'b1;
        end
      end
      ST_EX: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_ARITH:     alu_class = ALU_FUNCT;
          OP_ARITH_IMM: begin
            alu_src_b = SRCB_IMM;
            alu_class = ALU_FUNCT;
          end
          OP_LOAD, OP_STORE, OP_JALR: alu_src_b = SRCB_IMM;
          OP_BRANCH: begin
            alu_class = ALU_BRANCH;
            pc_write  = 1'b1;
            pc_source = bcond ? PCSRC_ALUOUT : PCSRC_PC4;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        i_or_d_c    = 1'b1;
        mem_read_c  = (opcode == OP_LOAD);
        mem_write_c = (opcode == OP_STORE);
        pc_write    = (opcode == OP_STORE) && mem.mem_ready;
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (opcode)
          OP_LOAD: mem_to_reg = WB_MDR;
          OP_JAL: begin
            mem_to_reg = WB_PC4;
            pc_source  = PCSRC_ALUOUT;
          end
          OP_JALR: begin
            // Keep the EX operands so the live ALU result is the jump target.
            mem_to_reg = WB_PC4;
            pc_source  = PCSRC_ALU;
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
          end
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_read  = mem_read_c;
  assign mem.mem_write = mem_write_c;
  assign mem.i_or_d    = i_or_d_c;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;
  import multi_cycle_control_unit_pkg::*;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_class;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal_inst;
    logic       mem_timeout;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       bcond = 1'b0;
  logic       is_halt = 1'b0;
  logic       ir_write, reg_write, alu_src_a, pc_write;
  logic       halted, illegal_inst, mem_timeout;
  logic [1:0] mem_to_reg, alu_src_b, alu_class, pc_source;

  int checks = 0;
  int errors = 0;

  outs_t exp_q[$];
  string tag_q[$];
  outs_t mon_e, mon_o;
  string mon_t;
  outs_t e;

  multi_cycle_control_unit_if mif ();

  multi_cycle_control_unit #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .bcond        (bcond),
    .is_halt      (is_halt),
    .mem          (mif.master),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_class    (alu_class),
    .pc_write     (pc_write),
    .pc_source    (pc_source),
    .halted       (halted),
    .illegal_inst (illegal_inst),
    .mem_timeout  (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_o = {mif.mem_read, mif.mem_write, mif.i_or_d, ir_write, reg_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_class, pc_write, pc_source, halted, illegal_inst,
               mem_timeout};
      chk(mon_t, 32'(mon_o), 32'(mon_e));
    end
  end

  // Called just after a rising edge: drive this cycle's inputs, queue the
  // outputs expected in this cycle, advance to the next cycle.
  task automatic step(input string tag, input outs_t ex, input logic rdy, input logic bc,
                      input logic hlt);
    mif.mem_ready = rdy;
    bcond         = bc;
    is_halt       = hlt;
    exp_q.push_back(ex);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t e_if(input logic rdy);
    outs_t r = '0;
    r.mem_read  = 1'b1;
    r.alu_src_b = 2'd1;
    r.ir_write  = rdy;
    return r;
  endfunction

  function automatic outs_t e_id(input logic ill, input logic pcw);
    outs_t r = '0;
    r.alu_src_b    = 2'd2;
    r.illegal_inst = ill;
    r.pc_write     = pcw;
    return r;
  endfunction

  function automatic outs_t e_ex(input logic [1:0] srcb, input logic [1:0] cls);
    outs_t r = '0;
    r.alu_src_a = 1'b1;
    r.alu_src_b = srcb;
    r.alu_class = cls;
    return r;
  endfunction

  function automatic outs_t e_wb(input logic [1:0] m2r, input logic [1:0] pcs);
    outs_t r = '0;
    r.reg_write  = 1'b1;
    r.pc_write   = 1'b1;
    r.mem_to_reg = m2r;
    r.pc_source  = pcs;
    return r;
  endfunction

  initial begin
    mif.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset.c0", '0, 1'b1, 1'b0, 1'b0);
    step("reset.c1", '0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("rst_state", '0, 1'b1, 1'b0, 1'b0);

    // ADD: 4 cycles
    opcode = OP_ARITH;
    step("add.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("add.ID", e_id(1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    step("add.EX", e_ex(2'd0, 2'd2), 1'b1, 1'b0, 1'b0);
    step("add.WB", e_wb(2'd0, 2'd0), 1'b1, 1'b0, 1'b0);

    // ADDI with one fetch wait cycle
    opcode = OP_ARITH_IMM;
    step("addi.IFw", e_if(1'b0), 1'b0, 1'b0, 1'b0);
    step("addi.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("addi.ID", e_id(1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    step("addi.EX", e_ex(2'd2, 2'd2), 1'b1, 1'b0, 1'b0);
    step("addi.WB", e_wb(2'd0, 2'd0), 1'b1, 1'b0, 1'b0);

    // LW with three MEM wait cycles: 8 cycles total
    opcode = OP_LOAD;
    step("lw.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("lw.ID", e_id(1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    step("lw.EX", e_ex(2'd2, 2'd0), 1'b1, 1'b0, 1'b0);
    e = '0; e.mem_read = 1'b1; e.i_or_d = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("lw.MEMw%0d", i), e, 1'b0, 1'b0, 1'b0);
    step("lw.MEM", e, 1'b1, 1'b0, 1'b0);
    step("lw.WB", e_wb(2'd1, 2'd0), 1'b1, 1'b0, 1'b0);

    // SW with one MEM wait cycle
    opcode = OP_STORE;
    step("sw.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("sw.ID", e_id(1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    step("sw.EX", e_ex(2'd2, 2'd0), 1'b1, 1'b0, 1'b0);
    e = '0; e.mem_write = 1'b1; e.i_or_d = 1'b1;
    step("sw.MEMw", e, 1'b0, 1'b0, 1'b0);
    e.pc_write = 1'b1;
    step("sw.MEM", e, 1'b1, 1'b0, 1'b0);

    // BEQ taken then not taken
    opcode = OP_BRANCH;
    for (int t = 1; t >= 0; t--) begin
      step("beq.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
      step("beq.ID", e_id(1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
      e = e_ex(2'd0, 2'd1);
      e.pc_write  = 1'b1;
      e.pc_source = (t == 1) ? 2'd2 : 2'd0;
      step($sformatf("beq.EX.b%0d", t), e, 1'b1, t[0], 1'b0);
    end

    // JAL: 3 cycles
    opcode = OP_JAL;
    step("jal.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("jal.ID", e_id(1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    step("jal.WB", e_wb(2'd2, 2'd2), 1'b1, 1'b0, 1'b0);

    // JALR: ALU operands held through WB
    opcode = OP_JALR;
    step("jalr.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("jalr.ID", e_id(1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    step("jalr.EX", e_ex(2'd2, 2'd0), 1'b1, 1'b0, 1'b0);
    e = e_wb(2'd2, 2'd1); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    step("jalr.WB", e, 1'b1, 1'b0, 1'b0);

    // LUI is not decoded: illegal pulse, retires as NOP
    opcode = 7'b0110111;
    step("ill.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("ill.ID", e_id(1'b1, 1'b1), 1'b1, 1'b0, 1'b0);

    // ECALL without halt
    opcode = OP_ECALL;
    step("ecall.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("ecall.ID", e_id(1'b0, 1'b1), 1'b1, 1'b0, 1'b0);

    // ECALL with halt: absorbing HALT, cleared only by reset
    step("halt.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);
    step("halt.ID", e_id(1'b0, 1'b0), 1'b1, 1'b0, 1'b1);
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("halt.H%0d", i), e, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    step("halt.rst", '0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("halt.rst_state", '0, 1'b0, 1'b0, 1'b0);

    // Refetch stalls: timeout after 4 wait cycles, FSM keeps waiting
    for (int i = 0; i < 4; i++) step($sformatf("tmo.w%0d", i), e_if(1'b0), 1'b0, 1'b0, 1'b0);
    e = e_if(1'b0); e.mem_timeout = 1'b1;
    step("tmo.set0", e, 1'b0, 1'b0, 1'b0);
    step("tmo.set1", e, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-wait drops the request at once
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst.mem_read", 32'(mif.mem_read), 32'd0);
    chk("async_rst.mem_timeout", 32'(mem_timeout), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("post.rst_state", '0, 1'b1, 1'b0, 1'b0);
    step("post.IF", e_if(1'b1), 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
